// File: rtl/fft_pkg.sv
// Shared FFT parameters and the one-hot control-state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: N (FFT length), M (log2 N), W (bin component width), RUN/DRAIN/DONE codes.
package fft_pkg;

   localparam int N = 8;
   localparam int M = $clog2(N);
   localparam int W = 32;

   // One-hot control states; the FFT core decodes the same codes.
   localparam logic [2:0] S_RUN   = 3'b001;
   localparam logic [2:0] S_DRAIN = 3'b010;
   localparam logic [2:0] S_DONE  = 3'b100;

   typedef enum logic [2:0] {
      RUN   = S_RUN,
      DRAIN = S_DRAIN,
      DONE  = S_DONE
   } state_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Registered squared-magnitude unit: mag = re*re + im*im at full 2W+1 width.
// Latency: 1 cycle; index and valid travel alongside the result.
// Backpressure: none; accepts a sample every cycle src_valid is high.
// Ports: clk, reset_n (sync, active-low), src_valid/src_re/src_im/src_idx in;
//        mag, mag_valid, mag_idx out.
module fft_mag_sq
   import fft_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                src_valid,
   input  logic signed [W-1:0] src_re,
   input  logic signed [W-1:0] src_im,
   input  logic [M-1:0]        src_idx,
   output logic [2*W:0]        mag,
   output logic                mag_valid,
   output logic [M-1:0]        mag_idx
);

   // Operands are sign-extended to 2W bits first so the product is formed at
   // full width; (-2^31)^2 = 2^62 still fits as a non-negative 2W-bit value.
   logic signed [2*W-1:0] re_x;
   logic signed [2*W-1:0] im_x;
   logic signed [2*W-1:0] re_sq;
   logic signed [2*W-1:0] im_sq;

   assign re_x  = {{W{src_re[W-1]}}, src_re};
   assign im_x  = {{W{src_im[W-1]}}, src_im};
   assign re_sq = re_x * re_x;
   assign im_sq = im_x * im_x;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mag_valid <= 1'b0;
      end else begin
         mag_valid <= src_valid;
      end
      // Both squares are non-negative, so zero-extending by one bit before
      // the add keeps the carry of the largest possible sum (2^63).
      if (src_valid) begin
         mag     <= {1'b0, re_sq} + {1'b0, im_sq};
         mag_idx <= src_idx;
      end
   end

endmodule

// File: rtl/fft_peak_detect.sv
// Finds the bin in 1..N/2-1 with the largest squared magnitude in one FFT frame.
// Latency: result valid two edges after the last bin is accepted; held until ack.
// Backpressure: in_ready drops from the last bin until ack; source must hold data.
// Ports: clk, reset_n (sync, active-low), in_valid/in_ready/in_re/in_im bin stream,
//        out_valid/ack result handshake, peak_idx/peak_mag result.
module fft_peak_detect
   import fft_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] in_re,
   input  logic signed [W-1:0] in_im,
   output logic                out_valid,
   input  logic                ack,
   output logic [M-1:0]        peak_idx,
   output logic [2*W:0]        peak_mag
);

   state_t         state;
   logic [M-1:0]   cnt;
   logic [M-1:0]   best_idx;
   logic [2*W:0]   best_mag;
   logic           accept;
   logic           s1_valid;
   logic [M-1:0]   s1_idx;
   logic [2*W:0]   s1_mag;
   logic           s1_in_range;
   logic           last_beat;

   assign accept    = in_valid && in_ready;
   assign last_beat = (cnt == M'(N - 1));

   fft_mag_sq u_mag_sq (
      .clk       (clk),
      .reset_n   (reset_n),
      .src_valid (accept),
      .src_re    (in_re),
      .src_im    (in_im),
      .src_idx   (cnt),
      .mag       (s1_mag),
      .mag_valid (s1_valid),
      .mag_idx   (s1_idx)
   );

   // DC and the mirrored upper half never compete for the peak.
   assign s1_in_range = (s1_idx != '0) && (s1_idx < M'(N / 2));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= RUN;
         cnt       <= '0;
         best_idx  <= '0;
         best_mag  <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         // Strict compare: on a tie the earlier (lower) bin keeps the title.
         if (s1_valid && s1_in_range && (s1_mag > best_mag)) begin
            best_idx <= s1_idx;
            best_mag <= s1_mag;
         end

         case (state)
            RUN: begin
               if (accept) begin
                  cnt <= cnt + 1'b1;  // wraps to 0 after beat N-1
                  if (last_beat) begin
                     state    <= DRAIN;
                     in_ready <= 1'b0;
                  end
               end
            end
            // One cycle lets the last magnitude pass through the compare stage.
            DRAIN: begin
               state     <= DONE;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (ack) begin
                  state     <= RUN;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  cnt       <= '0;
                  best_idx  <= '0;
                  best_mag  <= '0;
               end
            end
            default: begin
               state     <= RUN;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               cnt       <= '0;
               best_idx  <= '0;
               best_mag  <= '0;
            end
         endcase
      end
   end

   assign peak_idx = best_idx;
   assign peak_mag = best_mag;

endmodule
